tl_tx_arbiter: RTL and testbench

Packet-atomic arbiter that shares the single TL transmit stream toward the DLL between NUM_SRC TLP producers. Source 0 is the completion generator (CplD/Cpl answering received MRd/CfgRd). Source 1 carries config-space completions. Source 2 carries user MWr/MRd requests. Fixed priority for source 0 is optional, the remaining sources are served round-robin, and a per-source starvation counter bounds wait time. The output is one registered beat stage with valid/ready.

---
 rtl/tl_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_tl_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_tx_arbiter.sv
// Packet-atomic TLP transmit arbiter: starvation override, optional source-0 priority,
// round-robin among the rest, and one registered valid/ready output beat toward the DLL.
module tl_tx_arbiter #(
    parameter int NUM_SRC   = 3,
    parameter int DATA_W    = 128,
    parameter int PRIO_SRC0 = 1,
    parameter int MAX_WAIT  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data_i,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    input  logic [NUM_SRC-1:0]            src_last_i,
    output logic [NUM_SRC-1:0]            src_ready_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          out_valid_o,
    output logic                          out_last_o,
    output logic [$clog2(NUM_SRC)-1:0]    out_src_o,
    input  logic                          out_ready_i,
    output logic                          busy_o
);

    localparam int                 SRC_W    = $clog2(NUM_SRC);
    localparam logic [3:0]         WAIT_MAX = 4'(MAX_WAIT);
    localparam logic [SRC_W-1:0]   LAST_IDX = SRC_W'(NUM_SRC - 1);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                        state_reg;
    logic [SRC_W-1:0]              rr_ptr_reg;
    logic [SRC_W-1:0]              lock_src_reg;
    logic [NUM_SRC-1:0][3:0]       wait_cnt_reg;
    logic [NUM_SRC-1:0][3:0]       wait_cnt_next;
    logic [DATA_W-1:0]             out_data_reg;
    logic                          out_valid_reg;
    logic                          out_last_reg;
    logic [SRC_W-1:0]              out_src_reg;

    logic                          slot_free;
    logic [NUM_SRC-1:0]            starved;
    logic [NUM_SRC-1:0]            rr_mask;
    logic                          starved_any;
    logic [SRC_W-1:0]              starved_idx;
    logic                          rr_any;
    logic [SRC_W-1:0]              rr_idx;
    logic                          prio_hit;
    logic                          win_valid;
    logic [SRC_W-1:0]              win_idx;
    logic                          grant_en;
    logic [SRC_W-1:0]              grant_idx;
    logic                          xfer;
    logic                          xfer_last;
    logic                          grant_evt;
    logic [SRC_W-1:0]              rr_next;

    assign slot_free = !out_valid_reg || out_ready_i;

    // With source-0 priority enabled, source 0 never takes part in the round-robin scan.
    assign rr_mask = (PRIO_SRC0 != 0) ? (src_valid_i & ~NUM_SRC'(1)) : src_valid_i;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign starved[gi] = src_valid_i[gi] && (wait_cnt_reg[gi] == WAIT_MAX);

        assign wait_cnt_next[gi] =
            !grant_evt                       ? wait_cnt_reg[gi] :
            (win_idx == SRC_W'(gi))          ? 4'd0 :
            !src_valid_i[gi]                 ? wait_cnt_reg[gi] :
            (wait_cnt_reg[gi] >= WAIT_MAX)   ? WAIT_MAX :
                                               wait_cnt_reg[gi] + 4'd1;
    end

    always_comb begin
        int cand;
        cand        = 0;
        starved_any = 1'b0;
        starved_idx = '0;
        rr_any      = 1'b0;
        rr_idx      = '0;
        // Descending scans so the last hit is the lowest index / smallest rr offset.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (starved[i]) begin
                starved_any = 1'b1;
                starved_idx = SRC_W'(i);
            end
        end
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            cand = int'(rr_ptr_reg) + off;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (rr_mask[cand]) begin
                rr_any = 1'b1;
                rr_idx = SRC_W'(cand);
            end
        end
    end

    assign prio_hit  = (PRIO_SRC0 != 0) && src_valid_i[0];
    assign win_valid = starved_any || prio_hit || rr_any;
    assign win_idx   = starved_any ? starved_idx :
                       prio_hit    ? '0 :
                                     rr_idx;

    assign grant_en  = (state_reg == ST_LOCK) ? 1'b1 : win_valid;
    assign grant_idx = (state_reg == ST_LOCK) ? lock_src_reg : win_idx;

    assign src_ready_o = (rst_n && slot_free && grant_en) ? (NUM_SRC'(1) << grant_idx) : '0;
    assign xfer        = |(src_ready_o & src_valid_i);
    assign xfer_last   = src_last_i[grant_idx];
    assign grant_evt   = xfer && (state_reg == ST_ARB);
    assign rr_next     = (win_idx == LAST_IDX) ? '0 : win_idx + SRC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_ARB;
            rr_ptr_reg    <= '0;
            lock_src_reg  <= '0;
            wait_cnt_reg  <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_src_reg   <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;

            if (xfer) begin
                out_data_reg  <= src_data_i[grant_idx*DATA_W +: DATA_W];
                out_valid_reg <= 1'b1;
                out_last_reg  <= xfer_last;
                out_src_reg   <= grant_idx;
            end else if (slot_free) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_ARB: begin
                    if (xfer) begin
                        rr_ptr_reg <= rr_next;
                        if (!xfer_last) begin
                            state_reg    <= ST_LOCK;
                            lock_src_reg <= win_idx;
                        end
                    end
                end
                ST_LOCK: begin
                    if (xfer && xfer_last) begin
                        state_reg <= ST_ARB;
                    end
                end
                default: state_reg <= ST_ARB;
            endcase
        end
    end

    assign out_data_o  = out_data_reg;
    assign out_valid_o = out_valid_reg;
    assign out_last_o  = out_last_reg;
    assign out_src_o   = out_src_reg;
    assign busy_o      = (state_reg == ST_LOCK);

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Bench for tl_tx_arbiter: one priority instance and one pure round-robin instance,
// checked against a priority-key reference model plus directed corner-case sequences.
module tb_tl_tx_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int MW = 4;

    logic             clk;
    logic             rst_n;
    logic [N*W-1:0]   sdata  [2];
    logic [N-1:0]     svalid [2];
    logic [N-1:0]     slast  [2];
    logic [N-1:0]     sready [2];
    logic [W-1:0]     odata  [2];
    logic             ovalid [2];
    logic             olast  [2];
    logic [1:0]       osrc   [2];
    logic             oready [2];
    logic             busy   [2];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit           m_ov   [2];
    logic [W-1:0] m_od   [2];
    bit           m_ol   [2];
    int           m_os   [2];
    bit           m_lock [2];
    int           m_lsrc [2];
    int           m_rr   [2];
    int           m_wait [2][N];
    logic [N-1:0] acc    [2];
    int           del_cnt[2];

    tl_tx_arbiter #(.NUM_SRC(N), .DATA_W(W), .PRIO_SRC0(1), .MAX_WAIT(MW)) u_prio (
        .clk(clk), .rst_n(rst_n),
        .src_data_i(sdata[0]), .src_valid_i(svalid[0]), .src_last_i(slast[0]),
        .src_ready_o(sready[0]), .out_data_o(odata[0]), .out_valid_o(ovalid[0]),
        .out_last_o(olast[0]), .out_src_o(osrc[0]), .out_ready_i(oready[0]),
        .busy_o(busy[0])
    );

    tl_tx_arbiter #(.NUM_SRC(N), .DATA_W(W), .PRIO_SRC0(0), .MAX_WAIT(MW)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .src_data_i(sdata[1]), .src_valid_i(svalid[1]), .src_last_i(slast[1]),
        .src_ready_o(sready[1]), .out_data_o(odata[1]), .out_valid_o(ovalid[1]),
        .out_last_o(olast[1]), .out_src_o(osrc[1]), .out_ready_i(oready[1]),
        .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(int i, string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %0h, expected %0h at %0t", i, name, act, exp, $time);
        end
    endtask

    // Winner = valid source with the smallest priority key: starved sources by index,
    // then priority source 0, then round-robin distance from the pointer.
    function automatic int model_winner(int i);
        int best, best_key, key;
        best = -1;
        best_key = 1000;
        for (int k = 0; k < N; k++) begin
            if (svalid[i][k]) begin
                if (m_wait[i][k] >= MW)            key = k;
                else if (i == 0 && k == 0)         key = 50;
                else                               key = 100 + ((k - m_rr[i] + N) % N);
                if (key < best_key) begin
                    best_key = key;
                    best = k;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] model_ready(int i);
        int w;
        if (!rst_n) return '0;
        if (m_ov[i] && !oready[i]) return '0;
        if (m_lock[i]) return N'(1 << m_lsrc[i]);
        w = model_winner(i);
        return (w < 0) ? '0 : N'(1 << w);
    endfunction

    task automatic model_step(int i);
        logic [N-1:0] r;
        int k;
        r = model_ready(i);
        k = -1;
        for (int kk = 0; kk < N; kk++) if (r[kk] && svalid[i][kk]) k = kk;
        if (k >= 0) begin
            if (!m_lock[i]) begin
                for (int j = 0; j < N; j++)
                    if (j != k && svalid[i][j] && m_wait[i][j] < MW) m_wait[i][j]++;
                m_wait[i][k] = 0;
                m_rr[i] = (k + 1) % N;
            end
            m_lock[i] = !slast[i][k];
            m_lsrc[i] = k;
            m_ov[i]   = 1'b1;
            m_od[i]   = sdata[i][k*W +: W];
            m_ol[i]   = slast[i][k];
            m_os[i]   = k;
        end else if (!m_ov[i] || oready[i]) begin
            m_ov[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk(i, "src_ready", 32'(sready[i]), 32'(model_ready(i)));
                chk(i, "out_valid", 32'(ovalid[i]), 32'(m_ov[i]));
                chk(i, "busy", 32'(busy[i]), 32'(m_lock[i]));
                if (m_ov[i]) begin
                    chk(i, "out_data", odata[i], m_od[i]);
                    chk(i, "out_last", 32'(olast[i]), 32'(m_ol[i]));
                    chk(i, "out_src", 32'(osrc[i]), 32'(m_os[i]));
                end
                if (ovalid[i] && oready[i]) del_cnt[i]++;
                acc[i] = model_ready(i) & svalid[i];
                model_step(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(int i, int k, bit v, bit l, logic [W-1:0] d);
        svalid[i][k] = v;
        slast[i][k]  = l;
        sdata[i][k*W +: W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            svalid[i] = '1;
            slast[i]  = '0;
            sdata[i]  = '0;
            oready[i] = 1'b1;
            acc[i]    = '0;
            del_cnt[i] = 0;
            m_ov[i] = 0; m_od[i] = '0; m_ol[i] = 0; m_os[i] = 0;
            m_lock[i] = 0; m_lsrc[i] = 0; m_rr[i] = 0;
            for (int k = 0; k < N; k++) m_wait[i][k] = 0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(i, "rst_out_valid", 32'(ovalid[i]), 0);
            chk(i, "rst_out_data", odata[i], 0);
            chk(i, "rst_out_last", 32'(olast[i]), 0);
            chk(i, "rst_out_src", 32'(osrc[i]), 0);
            chk(i, "rst_busy", 32'(busy[i]), 0);
            chk(i, "rst_src_ready", 32'(sready[i]), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) svalid[i] = '0;
    endtask

    typedef struct {
        int           inst;
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
        logic         exp_ov;
        logic [1:0]   exp_src;
    } vec_t;

    vec_t vecs[16];
    int   b, b2;
    bit   s0_done;
    int   rem[N];

    initial begin
        // Round-robin instance, all sources continuously valid with 1-beat packets.
        vecs[0]  = '{1, 3'b111, 3'b001, 1'b0, 2'd0};
        vecs[1]  = '{1, 3'b111, 3'b010, 1'b1, 2'd0};
        vecs[2]  = '{1, 3'b111, 3'b100, 1'b1, 2'd1};
        vecs[3]  = '{1, 3'b111, 3'b001, 1'b1, 2'd2};
        vecs[4]  = '{1, 3'b111, 3'b010, 1'b1, 2'd0};
        vecs[5]  = '{1, 3'b111, 3'b100, 1'b1, 2'd1};
        vecs[6]  = '{1, 3'b000, 3'b000, 1'b1, 2'd2};
        vecs[7]  = '{1, 3'b000, 3'b000, 1'b0, 2'd0};
        // Priority instance: src0 wins four grants, then starved src1, then src0 again.
        vecs[8]  = '{0, 3'b011, 3'b001, 1'b0, 2'd0};
        vecs[9]  = '{0, 3'b011, 3'b001, 1'b1, 2'd0};
        vecs[10] = '{0, 3'b011, 3'b001, 1'b1, 2'd0};
        vecs[11] = '{0, 3'b011, 3'b001, 1'b1, 2'd0};
        vecs[12] = '{0, 3'b011, 3'b010, 1'b1, 2'd0};
        vecs[13] = '{0, 3'b011, 3'b001, 1'b1, 2'd1};
        vecs[14] = '{0, 3'b011, 3'b001, 1'b1, 2'd0};
        vecs[15] = '{0, 3'b000, 3'b000, 1'b1, 2'd0};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            svalid[i] = '0; slast[i] = '0; sdata[i] = '0; oready[i] = 1'b1;
        end
        @(posedge clk);
        #1;

        for (int s = 0; s < 16; s++) begin
            int vi, step;
            vi = vecs[s].inst;
            step = s % 8;
            if (step == 0) do_reset();
            for (int k = 0; k < N; k++)
                set_src(vi, k, vecs[s].valid[k], 1'b1, {16'hC0DE, 8'(k), 8'(step)});
            #1;
            chk(vi, "tbl_ready", 32'(sready[vi]), 32'(vecs[s].exp_ready));
            chk(vi, "tbl_out_valid", 32'(ovalid[vi]), 32'(vecs[s].exp_ov));
            if (vecs[s].exp_ov) begin
                chk(vi, "tbl_out_src", 32'(osrc[vi]), 32'(vecs[s].exp_src));
                chk(vi, "tbl_out_data", odata[vi], {16'hC0DE, 6'd0, vecs[s].exp_src, 8'(step - 1)});
            end
            tick();
        end

        // Three-beat packet from src1, no backpressure.
        do_reset();
        b = 0;
        for (int c = 0; c < 6; c++) begin
            if (b < 3) set_src(0, 1, 1'b1, b == 2, 32'hD100_0000 + b);
            else       set_src(0, 1, 1'b0, 1'b0, '0);
            #1;
            if (c >= 1 && c <= 3) begin
                chk(0, "t1_valid", 32'(ovalid[0]), 1);
                chk(0, "t1_data", odata[0], 32'hD100_0000 + c - 1);
                chk(0, "t1_last", 32'(olast[0]), 32'(c == 3));
                chk(0, "t1_src", 32'(osrc[0]), 1);
                chk(0, "t1_busy", 32'(busy[0]), 32'(c != 3));
            end
            if (c == 4) chk(0, "t1_idle", 32'(ovalid[0]), 0);
            tick();
            if (acc[0][1]) b++;
        end

        // src0 must wait for the locked src2 packet to finish.
        do_reset();
        b2 = 0;
        s0_done = 0;
        for (int c = 0; c < 9; c++) begin
            if (b2 < 4) set_src(0, 2, 1'b1, b2 == 3, 32'hE200_0000 + b2);
            else        set_src(0, 2, 1'b0, 1'b0, '0);
            if (b2 >= 2 && !s0_done) set_src(0, 0, 1'b1, 1'b1, 32'hF000_0000);
            else                     set_src(0, 0, 1'b0, 1'b0, '0);
            #1;
            if (b2 >= 2 && b2 < 4) chk(0, "t4_src0_blocked", 32'(sready[0][0]), 0);
            if (b2 == 4 && !s0_done) chk(0, "t4_src0_granted", 32'(sready[0][0]), 1);
            tick();
            if (acc[0][2]) b2++;
            if (acc[0][0]) s0_done = 1;
        end

        // Backpressure for three cycles in the middle of a 4-beat src1 packet.
        do_reset();
        b = 0;
        for (int c = 0; c < 10; c++) begin
            oready[1] = !(c >= 2 && c < 5);
            if (b < 4) set_src(1, 1, 1'b1, b == 3, 32'hD000_0000 + b);
            else       set_src(1, 1, 1'b0, 1'b0, '0);
            #1;
            if (c >= 2 && c < 5) begin
                chk(1, "t5_hold_data", odata[1], 32'hD000_0001);
                chk(1, "t5_no_ready", 32'(sready[1]), 0);
            end
            tick();
            if (acc[1][1]) b++;
        end
        chk(1, "t5_beats_delivered", 32'(del_cnt[1]), 4);

        // Reset during beat 2 of a 3-beat src1 packet, then rr restarts at 0.
        do_reset();
        b = 0;
        for (int c = 0; c < 2; c++) begin
            set_src(0, 1, 1'b1, 1'b0, 32'hA100_0000 + c);
            tick();
        end
        set_src(0, 1, 1'b1, 1'b1, 32'hA100_0002);
        #2;
        rst_n = 1'b0;
        #1;
        chk(0, "t6_valid_drop", 32'(ovalid[0]), 0);
        chk(0, "t6_busy_drop", 32'(busy[0]), 0);
        do_reset();
        set_src(0, 1, 1'b1, 1'b1, 32'hB100_0000);
        set_src(0, 2, 1'b1, 1'b1, 32'hB200_0000);
        #1;
        chk(0, "t6_rr_from_zero", 32'(sready[0]), 32'b010);
        tick();
        set_src(0, 1, 1'b0, 1'b0, '0);
        tick();
        set_src(0, 2, 1'b0, 1'b0, '0);
        tick();

        // Randomized packets, bubbles and backpressure on both instances.
        for (int i = 0; i < 2; i++) begin
            do_reset();
            for (int k = 0; k < N; k++) rem[k] = 0;
            for (int c = 0; c < 800; c++) begin
                for (int k = 0; k < N; k++) begin
                    if (svalid[i][k] && acc[i][k]) begin
                        rem[k]--;
                        svalid[i][k] = 1'b0;
                    end
                    if (!svalid[i][k]) begin
                        if (rem[k] == 0 && $urandom_range(2) == 0) rem[k] = $urandom_range(4, 1);
                        if (rem[k] > 0 && $urandom_range(3) != 0)
                            set_src(i, k, 1'b1, rem[k] == 1, $urandom);
                    end
                end
                oready[i] = ($urandom_range(3) != 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
